// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to a variable-latency instruction
// memory over req/ack, and holds the IF/ID register with a one-entry skid buffer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        IFID_Valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  state_t      state, state_nxt;
  ifid_t       ifid;
  logic [31:0] pc, pc_plus4, drop_addr;
  logic [31:0] skid_instr, skid_pc4;
  logic        accept;

  assign pc_plus4 = pc + 32'd4;
  assign accept   = !Stall || !ifid.valid;

  assign Instruction = ifid.instr;
  assign PCPlus4     = ifid.pc4;
  assign IFID_Valid  = ifid.valid;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (PCSrc)                              state_nxt = imem_ack ? S_FETCH : S_DROP;
        else if (imem_ack && Stall && ifid.valid) state_nxt = S_HOLD;
      end
      S_HOLD:  if (PCSrc || !Stall) state_nxt = S_FETCH;
      // an ack arriving with a second redirect still retires the aborted request
      S_DROP:  if (imem_ack) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
      end
      default: ;
    endcase
  end

  // HOLD state itself marks the skid entry as occupied
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc         <= RESET_PC;
      ifid       <= '{valid: 1'b0, pc4: 32'd0, instr: NOP_WORD};
      skid_instr <= NOP_WORD;
      skid_pc4   <= 32'd0;
      drop_addr  <= RESET_PC;
    end else if (PCSrc) begin
      pc          <= BranchTarget & ~32'h3;
      ifid.valid  <= 1'b0;
      ifid.instr  <= NOP_WORD;
      if (state == S_FETCH && !imem_ack) drop_addr <= pc;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            pc <= pc_plus4;
            if (accept) begin
              ifid <= '{valid: 1'b1, pc4: pc_plus4, instr: imem_rdata};
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_plus4;
            end
          end else if (accept) begin
            ifid.valid <= 1'b0;
            ifid.instr <= NOP_WORD;
          end
        end
        S_HOLD: if (!Stall) ifid <= '{valid: 1'b1, pc4: skid_pc4, instr: skid_instr};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a programmable-latency memory model,
// expected fetch addresses and IF/ID words queued per scenario and popped on use.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        imem_req, imem_ack, IFID_Valid;
  logic [31:0] imem_addr, imem_rdata, Instruction, PCPlus4;

  logic        rst2 = 1'b1;
  logic        req2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc4_2;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 0;
  int ack_limit = 0;
  int acks_given, wait_cnt;

  logic [31:0] exp_addr[$];
  ifid_exp_t   exp_ifid[$];

  always #5 Clk = ~Clk;

  instruction_fetch_unit dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PCPlus4(PCPlus4), .IFID_Valid(IFID_Valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .Clk(Clk), .Rst(rst2), .Stall(1'b0), .PCSrc(1'b0), .BranchTarget(32'd0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(rdata2),
    .Instruction(instr2), .PCPlus4(pc4_2), .IFID_Valid(valid2)
  );

  assign rdata2     = addr2 | 32'hA000_0000;
  assign imem_ack   = imem_req && (wait_cnt >= lat) && (acks_given < ack_limit);
  assign imem_rdata = imem_ack ? (imem_addr | 32'hA000_0000) : 32'hDEAD_BEEF;

  always @(posedge Clk) begin
    if (Rst) begin
      acks_given <= 0;
      wait_cnt   <= 0;
    end else if (imem_ack) begin
      acks_given <= acks_given + 1;
      wait_cnt   <= 0;
    end else if (imem_req) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic push_addr(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic push_word(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_ifid.push_back('{instr: a | 32'hA000_0000, pc4: a + 32'd4});
  endtask

  task automatic do_reset();
    Rst = 1'b1; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = 32'd0;
    lat = 0; ack_limit = 0;
    step(1);
    sample();
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_valid", 32'(IFID_Valid), 32'd0);
    chk("rst_instr", Instruction,     32'd0);
    chk("rst_pc4",   PCPlus4,         32'd0);
    step(1);
    Rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (exp_addr.size() != 0 || exp_ifid.size() != 0); i++) step(1);
    chk("addr_drained", 32'(exp_addr.size()), 32'd0);
    chk("ifid_drained", 32'(exp_ifid.size()), 32'd0);
    exp_addr.delete();
    exp_ifid.delete();
  endtask

  // decoder consumes IF/ID on every non-stalled edge; memory acks retire requests
  always @(negedge Clk) begin
    logic [31:0] a;
    ifid_exp_t   e;
    if (!Rst) begin
      if (imem_ack) begin
        if (exp_addr.size() == 0) chk("unexp_ack", 32'(imem_ack), 32'd0);
        else begin
          a = exp_addr.pop_front();
          chk("req_addr", imem_addr, a);
        end
      end
      if (IFID_Valid && !Stall) begin
        if (exp_ifid.size() == 0) chk("unexp_ifid", 32'(IFID_Valid), 32'd0);
        else begin
          e = exp_ifid.pop_front();
          chk("instr",   Instruction, e.instr);
          chk("pcplus4", PCPlus4,     e.pc4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // zero-latency streaming
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'(i * 4));
    ack_limit = 6;
    sample();
    chk("idle_req", 32'(imem_req), 32'd0);
    step(1); sample();
    chk("first_req",  32'(imem_req), 32'd1);
    chk("first_addr", imem_addr,     32'd0);
    step(1); sample();
    chk("second_valid", 32'(IFID_Valid), 32'd1);
    drain(20);

    // two-cycle latency memory
    do_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) push_word(32'(i * 4));
    ack_limit = 4;
    sample();
    for (int i = 0; i < 20 && !IFID_Valid; i++) begin step(1); sample(); end
    chk("lat_first_valid", 32'(IFID_Valid), 32'd1);
    chk("lat_addr0", imem_addr, 32'h4);
    step(1); sample();
    chk("lat_valid1", 32'(IFID_Valid), 32'd0);
    chk("lat_addr1",  imem_addr,       32'h4);
    step(1); sample();
    chk("lat_valid2", 32'(IFID_Valid), 32'd0);
    chk("lat_addr2",  imem_addr,       32'h4);
    step(1); sample();
    chk("lat_valid3", 32'(IFID_Valid), 32'd1);
    drain(30);

    // stall while the 0x10 word arrives: it goes to the skid buffer
    do_reset();
    for (int i = 0; i < 7; i++) push_word(32'(i * 4));
    ack_limit = 7;
    step(5);
    Stall = 1'b1;
    step(1); sample();
    chk("hold_instr", Instruction,     32'hA000_000C);
    chk("hold_req",   32'(imem_req),   32'd0);
    step(1); sample();
    chk("hold_instr2", Instruction,   32'hA000_000C);
    chk("hold_req2",   32'(imem_req), 32'd0);
    step(1);
    Stall = 1'b0;
    sample();
    chk("hold_keep", Instruction, 32'hA000_000C);
    step(1); sample();
    chk("skid_instr", Instruction, 32'hA000_0010);
    chk("skid_pc4",   PCPlus4,     32'h14);
    chk("skid_next",  imem_addr,   32'h14);
    drain(20);

    // redirect while 0x20 is outstanding
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'(i * 4));
    push_addr(32'h20);
    for (int i = 0; i < 3; i++) push_word(32'h100 + 32'(i * 4));
    ack_limit = 8;
    step(10);
    PCSrc = 1'b1; BranchTarget = 32'h0000_0103;
    step(1);
    PCSrc = 1'b0;
    sample();
    chk("drop_req",   32'(imem_req),   32'd1);
    chk("drop_addr",  imem_addr,       32'h20);
    chk("drop_valid", 32'(IFID_Valid), 32'd0);
    chk("drop_instr", Instruction,     32'd0);
    step(1);
    ack_limit = 12;
    sample();
    chk("drop_addr2", imem_addr, 32'h20);
    step(1); sample();
    chk("redir_addr",  imem_addr,       32'h100);
    chk("redir_valid", 32'(IFID_Valid), 32'd0);
    drain(30);

    // redirect coincident with ack and stall
    do_reset();
    push_word(32'h0);
    push_addr(32'h4);
    push_addr(32'h8);
    push_word(32'h200);
    push_word(32'h204);
    ack_limit = 5;
    step(3);
    Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h200;
    step(1);
    Stall = 1'b0; PCSrc = 1'b0;
    sample();
    chk("flush_instr", Instruction,     32'd0);
    chk("flush_valid", 32'(IFID_Valid), 32'd0);
    chk("flush_addr",  imem_addr,       32'h200);
    drain(20);

    // PC wrap and asynchronous reset mid-request
    Rst = 1'b1;
    step(1);
    rst2 = 1'b0;
    step(2); sample();
    chk("wrap_instr0", instr2, 32'hFFFF_FFF8);
    chk("wrap_pc4_0",  pc4_2,  32'hFFFF_FFFC);
    chk("wrap_addr0",  addr2,  32'hFFFF_FFFC);
    step(1); sample();
    chk("wrap_instr1", instr2, 32'hFFFF_FFFC);
    chk("wrap_pc4_1",  pc4_2,  32'h0);
    chk("wrap_addr1",  addr2,  32'h0);
    step(1); sample();
    chk("wrap_instr2", instr2, 32'hA000_0000);
    chk("wrap_pc4_2",  pc4_2,  32'h4);
    chk("wrap_req",    32'(req2), 32'd1);
    #2;
    rst2 = 1'b1;
    #1;
    chk("arst_req",   32'(req2),   32'd0);
    chk("arst_valid", 32'(valid2), 32'd0);
    chk("arst_instr", instr2,      32'd0);
    chk("arst_pc4",   pc4_2,       32'd0);
    chk("arst_addr",  addr2,       32'hFFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
